emergency_response: RTL and testbench

//  Consumes the emergency flags (sos_mode, weight_limit_exceeded) and turns them into car actions.

---
 rtl/emergency_response_if.sv | 40 ++++
 rtl/emergency_response.sv | 129 ++++++++++++
 tb/tb_emergency_response.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/emergency_response_if.sv
// Emergency response bus: level flags from the flag logic and car state in,
// car actions and FSM state out. The sos_count member exists only when the
// EMERGENCY_COUNT_EN macro is defined.
interface emergency_response_if
`ifdef EMERGENCY_COUNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic       door;
  logic       moving;
  logic       motion_inhibit;
  logic       door_open_req;
  logic       alarm;
  logic [2:0] state;
`ifdef EMERGENCY_COUNT_EN
  logic [CNT_W-1:0] sos_count;
`endif

`ifdef EMERGENCY_COUNT_EN
  modport master (
    output sos_mode, weight_limit_exceeded, door, moving,
    input  motion_inhibit, door_open_req, alarm, state, sos_count
  );
  modport slave (
    input  sos_mode, weight_limit_exceeded, door, moving,
    output motion_inhibit, door_open_req, alarm, state, sos_count
  );
`else
  modport master (
    output sos_mode, weight_limit_exceeded, door, moving,
    input  motion_inhibit, door_open_req, alarm, state
  );
  modport slave (
    input  sos_mode, weight_limit_exceeded, door, moving,
    output motion_inhibit, door_open_req, alarm, state
  );
`endif
endinterface

// File: rtl/emergency_response.sv
// Emergency response sequencer: turns SOS / overweight flags into motion
// inhibit, door-open request and alarm drive, sequencing
// stop -> hold -> timed recovery. All outputs are registered.
// Optional feature: define EMERGENCY_COUNT_EN to add the saturating
// sos_count output (entries into STOP).
module emergency_response #(
  parameter int BLINK_DIV      = 4,
  parameter int RECOVER_CYCLES = 8
`ifdef EMERGENCY_COUNT_EN
  ,
  parameter int CNT_W          = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  emergency_response_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STOP       = 3'd1,
    SOS_HOLD   = 3'd2,
    OVERWEIGHT = 3'd3,
    RECOVER    = 3'd4
  } state_t;

  // Blink counter runs over one full on/off period; recovery counter holds at its terminal.
  localparam int BW = $clog2(2 * BLINK_DIV + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_DIV);
  localparam logic [RW-1:0] REC_LAST   = RW'(RECOVER_CYCLES - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [RW-1:0] rec_cnt_q, rec_cnt_d;
  logic          motion_inhibit_q, motion_inhibit_d;
  logic          door_open_req_q, door_open_req_d;
  logic          alarm_q, alarm_d;
`ifdef EMERGENCY_COUNT_EN
  logic [CNT_W-1:0] sos_count_q, sos_count_d;
`endif

  // Next state and per-state counters; counters default to 0 so every entry starts them cleared.
  always_comb begin
    state_d     = state_q;
    blink_cnt_d = '0;
    rec_cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.sos_mode)                   state_d = STOP;
        else if (bus.weight_limit_exceeded) state_d = OVERWEIGHT;
      end
      STOP: begin
        if (!bus.moving) state_d = bus.sos_mode ? SOS_HOLD : RECOVER;
      end
      SOS_HOLD: begin
        if (!bus.sos_mode) state_d = RECOVER;
        else blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
      end
      OVERWEIGHT: begin
        if (bus.sos_mode)                    state_d = STOP;
        else if (!bus.weight_limit_exceeded) state_d = RECOVER;
      end
      RECOVER: begin
        if (bus.sos_mode)                   state_d = STOP;
        else if (bus.weight_limit_exceeded) state_d = OVERWEIGHT;
        else if (rec_cnt_q == REC_LAST) begin
          rec_cnt_d = rec_cnt_q;
          if (!bus.door) state_d = IDLE;
        end else begin
          rec_cnt_d = rec_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so they land registered.
  always_comb begin
    motion_inhibit_d = (state_d != IDLE);
    door_open_req_d  = (state_d == SOS_HOLD) || (state_d == OVERWEIGHT);
    alarm_d          = (state_d == OVERWEIGHT) ||
                       ((state_d == SOS_HOLD) && (blink_cnt_d < BLINK_ON));
  end

`ifdef EMERGENCY_COUNT_EN
  // Count each fresh entry into STOP, saturating at all-ones.
  always_comb begin
    sos_count_d = sos_count_q;
    if ((state_d == STOP) && (state_q != STOP) && (sos_count_q != '1))
      sos_count_d = sos_count_q + 1'b1;
  end
`endif

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      blink_cnt_q      <= '0;
      rec_cnt_q        <= '0;
      motion_inhibit_q <= 1'b0;
      door_open_req_q  <= 1'b0;
      alarm_q          <= 1'b0;
`ifdef EMERGENCY_COUNT_EN
      sos_count_q      <= '0;
`endif
    end else begin
      state_q          <= state_d;
      blink_cnt_q      <= blink_cnt_d;
      rec_cnt_q        <= rec_cnt_d;
      motion_inhibit_q <= motion_inhibit_d;
      door_open_req_q  <= door_open_req_d;
      alarm_q          <= alarm_d;
`ifdef EMERGENCY_COUNT_EN
      sos_count_q      <= sos_count_d;
`endif
    end
  end

  assign bus.state          = state_q;
  assign bus.motion_inhibit = motion_inhibit_q;
  assign bus.door_open_req  = door_open_req_q;
  assign bus.alarm          = alarm_q;
`ifdef EMERGENCY_COUNT_EN
  assign bus.sos_count      = sos_count_q;
`endif

endmodule

// File: tb/tb_emergency_response.sv
// Testbench for emergency_response (BLINK_DIV=4, RECOVER_CYCLES=8).
// Each cycle's expected outputs are queued as the stimulus is driven; the
// observed outputs are queued after the edge and each test compares the two.
module tb_emergency_response;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, sos, wt, door, mov;

`ifdef EMERGENCY_COUNT_EN
  emergency_response_if #(.CNT_W(8)) bus ();
  emergency_response_if #(.CNT_W(2)) bus2 ();
`else
  emergency_response_if bus ();
`endif

  assign bus.sos_mode              = sos;
  assign bus.weight_limit_exceeded = wt;
  assign bus.door                  = door;
  assign bus.moving                = mov;

`ifdef EMERGENCY_COUNT_EN
  assign bus2.sos_mode              = sos;
  assign bus2.weight_limit_exceeded = wt;
  assign bus2.door                  = door;
  assign bus2.moving                = mov;

  emergency_response #(.BLINK_DIV(4), .RECOVER_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  emergency_response #(.BLINK_DIV(4), .RECOVER_CYCLES(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));
`else
  emergency_response #(.BLINK_DIV(4), .RECOVER_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       mi;
    logic       dor;
    logic       al;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  // One clock: drive inputs, queue the expected outputs, capture the DUT after the edge.
  task automatic cyc(input logic rn, input logic s, input logic w, input logic d,
                     input logic m, input logic [2:0] st, input logic mi,
                     input logic dor, input logic al);
    obs_t e, o;
    reset_n = rn; sos = s; wt = w; door = d; mov = m;
    e.st = st; e.mi = mi; e.dor = dor; e.al = al;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.st = bus.state; o.mi = bus.motion_inhibit; o.dor = bus.door_open_req; o.al = bus.alarm;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    repeat (3) cyc(0, 1, 0, 0, 1, 3'd0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 3'd1, 1, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask

  task automatic test_sos_blink;
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    repeat (5) cyc(1, 1, 0, 0, 1, 3'd1, 1, 0, 0);
    repeat (4) cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 1);
    repeat (4) cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 1);
    repeat (8) cyc(1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sos_blink[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask

  task automatic test_overweight;
    repeat (5) cyc(1, 0, 1, 0, 0, 3'd3, 1, 1, 1);
    repeat (8) cyc(1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overweight[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask

  task automatic test_priority;
    repeat (3) cyc(1, 1, 1, 0, 1, 3'd1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 3'd2, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 3'd3, 1, 1, 1);
    cyc(1, 1, 1, 0, 1, 3'd1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 3'd2, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL priority[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask

  task automatic test_recover_door;
    cyc(1, 0, 1, 0, 0, 3'd3, 1, 1, 1);
    repeat (20) cyc(1, 0, 0, 1, 0, 3'd4, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 3'd3, 1, 1, 1);
    repeat (4) cyc(1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 3'd3, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 3'd1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL recover_door[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask

  task automatic test_back_to_back;
    cyc(1, 1, 0, 0, 0, 3'd1, 1, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 3'd1, 1, 0, 0);
    repeat (4) cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 1);
    repeat (2) cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 3'd0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 3'd1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 3'd2, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask

`ifdef EMERGENCY_COUNT_EN
  task automatic test_count;
    int exp8, exp2;
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    checks++;
    if (bus.sos_count !== 8'd0 || bus2.sos_count !== 2'd0) begin
      errors++;
      $display("FAIL count_reset: got %0d/%0d, expected 0/0", bus.sos_count, bus2.sos_count);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, 0, 0, 3'd1, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
      exp8 = k;
      exp2 = (k > 3) ? 3 : k;
      checks++;
      if (bus.sos_count !== 8'(exp8) || bus2.sos_count !== 2'(exp2)) begin
        errors++;
        $display("FAIL count_ep%0d: got %0d/%0d, expected %0d/%0d",
                 k, bus.sos_count, bus2.sos_count, exp8, exp2);
      end
    end
    cyc(0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    checks++;
    if (bus.sos_count !== 8'd0 || bus2.sos_count !== 2'd0) begin
      errors++;
      $display("FAIL count_clear: got %0d/%0d, expected 0/0", bus.sos_count, bus2.sos_count);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL count_seq[%0d]: got st=%0d mi=%b dor=%b al=%b, expected st=%0d mi=%b dor=%b al=%b",
                 i, o.st, o.mi, o.dor, o.al, e.st, e.mi, e.dor, e.al);
      end
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; sos = 1'b0; wt = 1'b0; door = 1'b0; mov = 1'b0;
    test_reset();
    test_sos_blink();
    test_overweight();
    test_priority();
    test_recover_door();
    test_back_to_back();
`ifdef EMERGENCY_COUNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
